// File: rtl/seg_display_arbiter.sv
// Round-robin shares a 4-digit 7-seg display among NUM_REQ signed 8-bit sources; grant->digits in 9 clocks.
// No backpressure: REQ is a level, sampled only in IDLE; a granted value always dwells HOLD_CYCLES clocks.
module seg_display_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int SCAN_BITS   = 20
) (
    input  logic                   CLK100MHZ,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [8*NUM_REQ-1:0]   VAL,
    output logic [NUM_REQ-1:0]     GNT,
    output logic                   BUSY,
    output logic [3:0]             AN,
    output logic [6:0]             SEG
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;
    localparam int DW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CONV, SHOW} state_t;
    state_t state, next_state;

    logic [IW-1:0]        rr_ptr, gnt_idx, pick_idx;
    logic                 pick_vld;
    logic                 sign;
    logic [7:0]           mag, sel_val;
    logic [1:0]           bcd_h, h_n;
    logic [3:0]           bcd_t, bcd_o, t_adj, o_adj, t_n, o_n;
    logic [2:0]           bit_cnt;
    logic [DW-1:0]        dwell;
    logic                 dwell_done;
    logic                 disp_sign, valid;
    logic [3:0]           disp_h, disp_t, disp_o;
    logic [SCAN_BITS-1:0] refresh;
    logic                 grant_en, load_en, conv_en, conv_last, release_en;

    // First set REQ at or after rr_ptr; scanning downward lets the nearest one win.
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (REQ[idx[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = idx[IW-1:0];
            end
        end
    end

    assign sel_val    = VAL[{gnt_idx, 3'b000} +: 8];
    assign dwell_done = (dwell == DW'(HOLD_CYCLES - 1));

    always_ff @(posedge CLK100MHZ) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_vld) next_state = LOAD;
            LOAD:    next_state = CONV;
            CONV:    if (bit_cnt == 3'd7) next_state = SHOW;
            SHOW:    if (dwell_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant_en   = (state == IDLE) && pick_vld;
        load_en    = (state == LOAD);
        conv_en    = (state == CONV);
        conv_last  = conv_en && (bit_cnt == 3'd7);
        release_en = (state == SHOW) && dwell_done;
    end

    // One double-dabble step: correct nibbles >= 5, then shift mag's MSB in.
    always_comb begin
        o_adj = (bcd_o >= 4'd5) ? bcd_o + 4'd3 : bcd_o;
        t_adj = (bcd_t >= 4'd5) ? bcd_t + 4'd3 : bcd_t;
        h_n   = {bcd_h[0], t_adj[3]};
        t_n   = {t_adj[2:0], o_adj[3]};
        o_n   = {o_adj[2:0], mag[7]};
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            GNT <= '0;  BUSY <= 1'b0;  rr_ptr <= '0;  gnt_idx <= '0;
            sign <= 1'b0;  mag <= '0;  bcd_h <= '0;  bcd_t <= '0;  bcd_o <= '0;
            bit_cnt <= '0;  dwell <= '0;  refresh <= '0;  valid <= 1'b0;
            disp_sign <= 1'b0;  disp_h <= '0;  disp_t <= '0;  disp_o <= '0;
        end else begin
            refresh <= refresh + 1'b1;
            BUSY    <= (next_state != IDLE);
            if (grant_en) begin
                GNT     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                gnt_idx <= pick_idx;
            end
            if (load_en) begin
                sign    <= sel_val[7];
                mag     <= sel_val[7] ? (8'd0 - sel_val) : sel_val;
                bcd_h   <= '0;
                bcd_t   <= '0;
                bcd_o   <= '0;
                bit_cnt <= '0;
                dwell   <= '0;
            end
            if (conv_en) begin
                bcd_h   <= h_n;
                bcd_t   <= t_n;
                bcd_o   <= o_n;
                mag     <= {mag[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (conv_last) begin
                disp_sign <= sign;
                disp_h    <= {2'b00, h_n};
                disp_t    <= t_n;
                disp_o    <= o_n;
                valid     <= 1'b1;
            end
            if (state == SHOW) dwell <= dwell + 1'b1;
            if (release_en) begin
                GNT    <= '0;
                rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b0000001;
        endcase
    endfunction

    always_comb begin
        logic [1:0] sel;
        logic [3:0] nib;
        sel = refresh[SCAN_BITS-1 -: 2];
        AN  = 4'b1111;
        nib = 4'd0;
        case (sel)
            2'd0: AN = 4'b0111;
            2'd1: begin AN = 4'b1011; nib = disp_h; end
            2'd2: begin AN = 4'b1101; nib = disp_t; end
            default: begin AN = 4'b1110; nib = disp_o; end
        endcase
        if (!valid)          SEG = 7'b1111111;
        else if (sel == 2'd0) SEG = disp_sign ? 7'b1111110 : 7'b1111111;
        else                 SEG = seg_code(nib);
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: scoreboard of expected grant/digits, checked on negedges.
module tb_seg_display_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] val;
    logic [1:0]  gnt;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [3:0]  ref_cnt;

    always #5 clk = ~clk;

    seg_display_arbiter #(.NUM_REQ(2), .HOLD_CYCLES(16), .SCAN_BITS(4)) dut (
        .CLK100MHZ(clk), .RST(rst), .REQ(req), .VAL(val),
        .GNT(gnt), .BUSY(busy), .AN(an), .SEG(seg)
    );

    // Reference refresh counter: free-running, cleared by reset.
    always @(posedge clk) ref_cnt <= rst ? 4'd0 : ref_cnt + 4'd1;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [27:0] segs;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [6:0] dseg(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
            3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b0000001;
        endcase
    endfunction

    function automatic logic [27:0] enc(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return {(v < 0) ? 7'b1111110 : 7'b1111111, dseg(m / 100), dseg((m / 10) % 10), dseg(m % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scan_check(input string tag, input logic [27:0] segs, input bit blank);
        int s;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        s       = int'(ref_cnt[3:2]);
        exp_an  = 4'b1111 ^ (4'b1000 >> s);
        exp_seg = blank ? 7'b1111111 : segs[(3 - s) * 7 +: 7];
        chk({tag, "_an"}, 32'(an), 32'(exp_an));
        chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    task automatic wait_grant();
        int t;
        cur = sb.pop_front();
        t = 0;
        while (gnt === 2'b00 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("grant", 32'(gnt), 32'(cur.gnt));
        chk("busy_at_grant", 32'(busy), 32'd1);
    endtask

    task automatic show_check(input int skip);
        repeat (skip) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            chk("show_gnt", 32'(gnt), 32'(cur.gnt));
            chk("show_busy", 32'(busy), 32'd1);
            scan_check("show", cur.segs, 1'b0);
            @(negedge clk);
        end
        chk("release_gnt", 32'(gnt), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_an"}, 32'(an), 32'(4'b0111));
        chk({tag, "_seg"}, 32'(seg), 32'(7'b1111111));
    endtask

    initial begin
        int t;
        rst = 1'b1;
        req = 2'b00;
        val = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reset_check("reset");

        // Idle after reset: digits scan, segments blank.
        repeat (40) begin
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            scan_check("idle", 28'd0, 1'b1);
        end

        // Single requester, positive value.
        val[7:0] = 8'd127;
        req = 2'b01;
        sb.push_back('{gnt: 2'b01, segs: enc(127)});
        @(negedge clk);
        wait_grant();
        req = 2'b00;
        show_check(9);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_check("reset2");

        // Both requesting: strict alternation, negative values including -128.
        val = {8'h80, 8'hFB};
        req = 2'b11;
        sb.push_back('{gnt: 2'b01, segs: enc(-5)});
        sb.push_back('{gnt: 2'b10, segs: enc(-128)});
        sb.push_back('{gnt: 2'b01, segs: enc(-5)});
        for (int r = 0; r < 3; r++) begin
            wait_grant();
            show_check(9);
        end
        req = 2'b00;

        // One-cycle request pulse still gets a full dwell; display then persists.
        val[15:8] = 8'd42;
        sb.push_back('{gnt: 2'b10, segs: enc(42)});
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        wait_grant();
        show_check(9);
        repeat (24) begin
            @(negedge clk);
            chk("hold_gnt", 32'(gnt), 32'd0);
            chk("hold_busy", 32'(busy), 32'd0);
            scan_check("hold", enc(42), 1'b0);
        end

        // Reset mid-conversion of 99: display returns to blank, 99 never shown.
        val[7:0] = 8'd99;
        req = 2'b01;
        t = 0;
        @(negedge clk);
        while (gnt === 2'b00 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("abort_grant", 32'(gnt), 32'(2'b01));
        req = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_check("abort");
        rst = 1'b0;
        repeat (16) begin
            @(negedge clk);
            scan_check("abort_blank", 28'd0, 1'b1);
        end
        val[7:0] = 8'hF9;
        sb.push_back('{gnt: 2'b01, segs: enc(-7)});
        req = 2'b01;
        @(negedge clk);
        wait_grant();
        req = 2'b00;
        show_check(9);

        // VAL change after LOAD must not affect the displayed value.
        val[7:0] = 8'd55;
        sb.push_back('{gnt: 2'b01, segs: enc(55)});
        req = 2'b01;
        @(negedge clk);
        wait_grant();
        req = 2'b00;
        repeat (3) @(negedge clk);
        val[7:0] = 8'd200;
        show_check(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
